memory_arbiter: RTL and testbench

//  Shares one single-ported memory between the core's fetch port (i_*) and memory-stage data port (d_*).

---
 rtl/memory_arbiter_if.sv | 48 ++++
 rtl/memory_arbiter.sv | 142 ++++++++++++++
 tb/tb_memory_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bundle of every signal between the arbiter, the core's fetch/data ports and
// the memory. The master modport is the arbiter's view: it takes requests from
// the core and responses from the memory, and it drives grants, read data and
// memory commands. The slave modport is the environment's view of the same wires.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_start;
    logic              i_ready;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_inst;
    logic              i_inst_valid;

    logic [2:0]        d_cmd;
    logic              d_cmd_ready;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_wmask;
    logic [31:0]       d_rdata;
    logic              d_rdata_valid;

    logic              mem_start;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_wmask;
    logic [31:0]       mem_rdata;
    logic              mem_rdata_valid;

    modport master (
        input  i_start, i_addr,
        input  d_cmd, d_addr, d_wdata, d_wmask,
        input  mem_ready, mem_rdata, mem_rdata_valid,
        output i_ready, i_inst, i_inst_valid,
        output d_cmd_ready, d_rdata, d_rdata_valid,
        output mem_start, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output i_start, i_addr,
        output d_cmd, d_addr, d_wdata, d_wmask,
        output mem_ready, mem_rdata, mem_rdata_valid,
        input  i_ready, i_inst, i_inst_valid,
        input  d_cmd_ready, d_rdata, d_rdata_valid,
        input  mem_start, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one single-ported memory between the fetch and data ports of the core.
// Data has priority; after MAX_D_STREAK data grants in a row while fetch waits,
// fetch gets the next grant. Only one read is ever outstanding.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no read outstanding; grant issued combinationally
// I_WAIT | fetch read accepted by memory, waiting for mem_rdata_valid
// D_WAIT | data read accepted by memory, waiting for mem_rdata_valid
module memory_arbiter #(
    parameter int          ADDR_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    memory_arbiter_if.master   bus,
    output logic               err_unexp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic [31:0]       i_inst_q, i_inst_d;
    logic              i_inst_valid_q, i_inst_valid_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              d_rdata_valid_q, d_rdata_valid_d;
    logic              err_q, err_d;

    logic              in_idle;
    logic              d_req;
    logic              i_req;
    logic              grant_i;
    logic              grant_d;
    logic              accept;
    logic [ADDR_W-1:0] mem_addr_sel;

    // Grant and memory command mux; rst_n gating keeps every output low while reset is held.
    always_comb begin
        in_idle      = (state_q == IDLE) && rst_n;
        d_req        = (bus.d_cmd == 3'd1) || (bus.d_cmd == 3'd2);
        i_req        = bus.i_start;
        grant_i      = in_idle && i_req && (!d_req || (streak_q == STREAK_MAX));
        grant_d      = in_idle && d_req && !grant_i;
        accept       = (grant_i || grant_d) && bus.mem_ready;
        mem_addr_sel = '0;
        if (grant_i) begin
            mem_addr_sel = bus.i_addr;
        end else if (grant_d) begin
            mem_addr_sel = bus.d_addr;
        end
    end

    assign bus.mem_start     = grant_i || grant_d;
    assign bus.mem_we        = grant_d && (bus.d_cmd == 3'd2);
    assign bus.mem_addr      = mem_addr_sel;
    assign bus.mem_wdata     = grant_d ? bus.d_wdata : 32'd0;
    assign bus.mem_wmask     = grant_d ? bus.d_wmask : 32'd0;
    assign bus.i_ready       = grant_i && bus.mem_ready;
    assign bus.d_cmd_ready   = grant_d && bus.mem_ready;
    assign bus.i_inst        = i_inst_q;
    assign bus.i_inst_valid  = i_inst_valid_q;
    assign bus.d_rdata       = d_rdata_q;
    assign bus.d_rdata_valid = d_rdata_valid_q;
    assign err_unexp         = err_q;

    // Next-state: transaction tracking, streak counter, read-data capture and stray-response flag.
    always_comb begin
        state_d         = state_q;
        streak_d        = streak_q;
        i_inst_d        = i_inst_q;
        i_inst_valid_d  = 1'b0;
        d_rdata_d       = d_rdata_q;
        d_rdata_valid_d = 1'b0;
        err_d           = err_q || (bus.mem_rdata_valid && (state_q == IDLE));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (grant_i) begin
                        state_d  = I_WAIT;
                        streak_d = 4'd0;
                    end else begin
                        if (bus.d_cmd == 3'd1) begin
                            state_d = D_WAIT;
                        end
                        if (!bus.i_start) begin
                            streak_d = 4'd0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end
                end
            end
            I_WAIT: begin
                if (bus.mem_rdata_valid) begin
                    i_inst_d       = bus.mem_rdata;
                    i_inst_valid_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            D_WAIT: begin
                if (bus.mem_rdata_valid) begin
                    d_rdata_d       = bus.mem_rdata;
                    d_rdata_valid_d = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            streak_q        <= 4'd0;
            i_inst_q        <= 32'd0;
            i_inst_valid_q  <= 1'b0;
            d_rdata_q       <= 32'd0;
            d_rdata_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            streak_q        <= streak_d;
            i_inst_q        <= i_inst_d;
            i_inst_valid_q  <= i_inst_valid_d;
            d_rdata_q       <= d_rdata_d;
            d_rdata_valid_q <= d_rdata_valid_d;
            err_q           <= err_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a small memory model answers accepted reads
// after a fixed latency, expected read data is queued when a read is driven and
// popped when the matching valid pulse appears.
module tb_memory_arbiter;
    localparam int ADDR_W = 32;
    localparam int MAXS   = 4;
    localparam int LAT    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_unexp;

    memory_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    memory_arbiter #(.ADDR_W(ADDR_W), .MAX_D_STREAK(MAXS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_unexp (err_unexp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    int i_valid_cnt = 0;
    int d_valid_cnt = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory model: read accepted at edge E answers with a one-cycle valid in cycle E+LAT.
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;
    logic        m_valid = 1'b0;
    logic        stray = 1'b0;
    assign bus.mem_rdata_valid = m_valid | stray;

    initial bus.mem_rdata = '0;

    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (m_pend) begin
            if (m_cnt == 0) begin
                m_valid       <= 1'b1;
                bus.mem_rdata <= mem_fn(m_addr);
                m_pend        <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
        if (bus.mem_start && bus.mem_ready && !bus.mem_we) begin
            m_pend <= 1'b1;
            m_cnt  <= LAT - 2;
            m_addr <= bus.mem_addr;
        end
    end

    // Scoreboard side: compare every valid pulse against the queued expectation.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            checks++;
            assert (!(bus.i_ready && bus.d_cmd_ready)) else begin
                failures++;
                $error("FAIL both_ready observed=1 expected=0");
            end
            if (bus.i_inst_valid) begin
                i_valid_cnt++;
                checks++;
                if (exp_i_q.size() == 0) begin
                    failures++;
                    $error("FAIL i_unexpected_valid observed=%h expected=none", bus.i_inst);
                end else begin
                    logic [31:0] e;
                    e = exp_i_q.pop_front();
                    assert (bus.i_inst === e) else begin
                        failures++;
                        $error("FAIL i_inst observed=%h expected=%h", bus.i_inst, e);
                    end
                end
            end
            if (bus.d_rdata_valid) begin
                d_valid_cnt++;
                checks++;
                if (exp_d_q.size() == 0) begin
                    failures++;
                    $error("FAIL d_unexpected_valid observed=%h expected=none", bus.d_rdata);
                end else begin
                    logic [31:0] e;
                    e = exp_d_q.pop_front();
                    assert (bus.d_rdata === e) else begin
                        failures++;
                        $error("FAIL d_rdata observed=%h expected=%h", bus.d_rdata, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.i_ready;
            1:       return bus.i_inst_valid;
            2:       return bus.d_rdata_valid;
            default: return bus.d_cmd_ready;
        endcase
    endfunction

    // Caller sits at negedge+3; checks this cycle, then advances up to max cycles.
    task automatic wait_sig(input int sel, input int max, input string tag);
        logic seen;
        int k;
        seen = sig(sel);
        k = 0;
        while (!seen && k < max) begin
            @(negedge clk);
            #3;
            seen = sig(sel);
            k++;
        end
        checks++;
        assert (seen === 1'b1) else begin
            failures++;
            $error("FAIL %s timeout observed=%b expected=1", tag, seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        int nwr;
        logic got_i;

        bus.i_start = 1'b0; bus.i_addr = '0;
        bus.d_cmd = 3'd0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;
        bus.mem_ready = 1'b1;

        // Reset state, with requests present
        @(negedge clk);
        bus.i_start = 1'b1; bus.d_cmd = 3'd1;
        #3;
        chk("rst_mem_start", 32'(bus.mem_start), 32'd0);
        chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
        chk("rst_d_ready", 32'(bus.d_cmd_ready), 32'd0);
        chk("rst_err", 32'(err_unexp), 32'd0);
        chk("rst_i_inst", bus.i_inst, 32'd0);
        bus.i_start = 1'b0; bus.d_cmd = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch only: ready in cycle 0, valid in cycle 3
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_addr = 32'h100;
        exp_i_q.push_back(32'h13);
        #3;
        chk("f_i_ready", 32'(bus.i_ready), 32'd1);
        chk("f_mem_addr", bus.mem_addr, 32'h100);
        chk("f_mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        bus.i_start = 1'b0;
        #3;
        chk("f_c1_mem_start", 32'(bus.mem_start), 32'd0);
        chk("f_c1_valid", 32'(bus.i_inst_valid), 32'd0);
        @(negedge clk); #3;
        chk("f_c2_valid", 32'(bus.i_inst_valid), 32'd0);
        @(negedge clk); #3;
        chk("f_c3_valid", 32'(bus.i_inst_valid), 32'd1);
        chk("f_c3_inst", bus.i_inst, 32'h13);

        // Both request with streak 0: data first
        @(negedge clk);
        bus.d_cmd = 3'd1; bus.d_addr = 32'h200;
        bus.i_start = 1'b1; bus.i_addr = 32'h104;
        exp_d_q.push_back(mem_fn(32'h200));
        exp_i_q.push_back(mem_fn(32'h104));
        nd = d_valid_cnt;
        #3;
        chk("both_d_ready", 32'(bus.d_cmd_ready), 32'd1);
        chk("both_i_ready", 32'(bus.i_ready), 32'd0);
        chk("both_mem_addr", bus.mem_addr, 32'h200);
        @(negedge clk);
        bus.d_cmd = 3'd0;
        #3;
        wait_sig(0, 10, "both_i_grant");
        chk("both_d_before_i", 32'(d_valid_cnt), 32'(nd + 1));
        @(negedge clk);
        bus.i_start = 1'b0;
        #3;
        wait_sig(1, 10, "both_i_valid");

        // Starvation limit: writes every cycle while fetch waits
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_addr = 32'h108;
        exp_i_q.push_back(mem_fn(32'h108));
        bus.d_cmd = 3'd2; bus.d_addr = 32'h300; bus.d_wdata = 32'h1111_0000; bus.d_wmask = '1;
        #3;
        chk("starve_mem_we", 32'(bus.mem_we), 32'd1);
        nwr = 0;
        got_i = 1'b0;
        for (int k = 0; k < 12 && !got_i; k++) begin
            if (k > 0) begin
                @(negedge clk);
                bus.d_addr = 32'h300 + 32'(4 * nwr);
                #3;
            end
            if (bus.i_ready) got_i = 1'b1;
            else if (bus.d_cmd_ready) nwr++;
        end
        chk("starve_fetch_granted", 32'(got_i), 32'd1);
        chk("starve_write_count", 32'(nwr), 32'(MAXS));
        @(negedge clk);
        bus.i_start = 1'b0; bus.d_cmd = 3'd0;
        #3;
        wait_sig(1, 10, "starve_i_valid");

        // Masked write: accepted once, no read response
        @(negedge clk);
        bus.d_cmd = 3'd2; bus.d_addr = 32'h400; bus.d_wdata = 32'hCAFE_BABE; bus.d_wmask = 32'h0000_FFFF;
        nd = d_valid_cnt;
        #3;
        chk("wr_d_ready", 32'(bus.d_cmd_ready), 32'd1);
        chk("wr_mem_we", 32'(bus.mem_we), 32'd1);
        chk("wr_mem_wmask", bus.mem_wmask, 32'h0000_FFFF);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hCAFE_BABE);
        @(negedge clk);
        bus.d_cmd = 3'd0;
        #3;
        chk("wr_ready_gone", 32'(bus.d_cmd_ready), 32'd0);
        repeat (4) @(negedge clk);
        #3;
        chk("wr_no_rvalid", 32'(d_valid_cnt), 32'(nd));

        // Reset in the middle of an outstanding data read
        @(negedge clk);
        bus.d_cmd = 3'd1; bus.d_addr = 32'h600;
        nd = d_valid_cnt;
        #3;
        chk("rmid_accept", 32'(bus.d_cmd_ready), 32'd1);
        @(negedge clk);
        bus.d_cmd = 3'd0; bus.i_start = 1'b1; bus.i_addr = 32'h700;
        rst_n = 1'b0;
        #3;
        chk("rmid_i_ready", 32'(bus.i_ready), 32'd0);
        chk("rmid_mem_start", 32'(bus.mem_start), 32'd0);
        chk("rmid_i_inst", bus.i_inst, 32'd0);
        chk("rmid_d_rdata", bus.d_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_i_q.push_back(mem_fn(32'h700));
        #3;
        chk("rmid_idle_grant", 32'(bus.i_ready), 32'd1);
        @(negedge clk);
        bus.i_start = 1'b0;
        #3;
        chk("rmid_late_err", 32'(err_unexp), 32'd1);
        chk("rmid_no_d_valid", 32'(d_valid_cnt), 32'(nd));
        wait_sig(1, 10, "rmid_i_valid");

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("rst2_err_clear", 32'(err_unexp), 32'd0);

        // Backpressure, then a stray response in IDLE
        @(negedge clk);
        bus.mem_ready = 1'b0; bus.d_cmd = 3'd1; bus.d_addr = 32'h500;
        nd = d_valid_cnt;
        #3;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #3;
            end
            chk("bp_mem_start", 32'(bus.mem_start), 32'd1);
            chk("bp_d_ready", 32'(bus.d_cmd_ready), 32'd0);
            chk("bp_mem_addr", bus.mem_addr, 32'h500);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        exp_d_q.push_back(mem_fn(32'h500));
        #3;
        chk("bp_release_ready", 32'(bus.d_cmd_ready), 32'd1);
        @(negedge clk);
        bus.d_cmd = 3'd0;
        #3;
        wait_sig(2, 10, "bp_d_valid");
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        #3;
        chk("stray_err", 32'(err_unexp), 32'd1);
        repeat (3) @(negedge clk);
        #3;
        chk("stray_err_sticky", 32'(err_unexp), 32'd1);
        chk("stray_no_d_valid", 32'(d_valid_cnt), 32'(nd + 1));
        chk("sb_i_drained", 32'(exp_i_q.size()), 32'd0);
        chk("sb_d_drained", 32'(exp_d_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
